// File: rtl/debug_view_sequencer_if.sv
// debug_view_sequencer_if: processor debug read ports (combinational register file, handshaked data memory).
interface debug_view_sequencer_if;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [15:0] mem_addr_o;
    logic        mem_req_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    modport master (output reg_addr_o, mem_addr_o, mem_req_o, input reg_data_i, mem_ack_i, mem_data_i);
    modport slave  (input reg_addr_o, mem_addr_o, mem_req_o, output reg_data_i, mem_ack_i, mem_data_i);
endinterface

// File: rtl/debug_view_sequencer.sv
// debug_view_sequencer: button/auto stepping of register and memory views, word fetch and 8-digit hex display.
module debug_view_sequencer #(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int SCAN_DIV         = 100_000,
    parameter int AUTO_STEP_CYCLES = 100_000_000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          switch_i,
    input  logic                          btn_next_i,
    input  logic                          btn_prev_i,
    input  logic                          auto_i,
    debug_view_sequencer_if.master        dbg,
    output logic [15:0]                   led_o,
    output logic [7:0]                    anode_o,
    output logic [6:0]                    seg_o,
    output logic                          busy_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int AW = $clog2(AUTO_STEP_CYCLES + 1);
    localparam logic [0:0] S_IDLE = 1'b0, S_REQ = 1'b1;
    localparam logic [6:0] HEX7 [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [1:0]    w_raw, w_pulse;
    logic          w_auto, w_next, w_prev, w_step, w_idle;
    logic [AW-1:0] r_auto_cnt;
    logic [4:0]    r_reg_addr;
    logic [15:0]   r_mem_addr;
    logic [0:0]    r_state;
    logic          r_sw_q, r_start;
    logic [31:0]   r_reg_q, r_mem_q, w_word;
    logic [SW-1:0] r_scan_cnt;
    logic [2:0]    r_digit;
    logic [3:0]    w_nib;

    assign w_raw = {btn_prev_i, btn_next_i};
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [1:0]    r_sync;
        logic          r_db, r_db_d;
        logic [DW-1:0] r_cnt;
        // The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_sync <= '0;
                r_db   <= 1'b0;
                r_db_d <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_sync <= {r_sync[0], w_raw[b]};
                r_db_d <= r_db;
                if (r_sync[1] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_cnt <= '0;
                    r_db  <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
        assign w_pulse[b] = r_db & ~r_db_d;
    end

    assign w_idle = r_state == S_IDLE;
    assign w_auto = auto_i && r_auto_cnt == AW'(AUTO_STEP_CYCLES - 1);
    assign w_next = (w_pulse[0] | w_auto) & ~w_pulse[1];
    assign w_prev = w_pulse[1] & ~(w_pulse[0] | w_auto);
    assign w_step = w_idle & (w_next | w_prev);

    always_ff @(posedge clk_i) begin
        if (rst_i || !auto_i || w_step || w_auto) r_auto_cnt <= '0;
        else r_auto_cnt <= r_auto_cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_reg_addr <= '0;
            r_mem_addr <= '0;
        end else if (w_step && !switch_i) begin
            r_reg_addr <= w_next ? r_reg_addr + 5'd1 : r_reg_addr - 5'd1;
        end else if (w_step) begin
            r_mem_addr <= w_next ? r_mem_addr + 16'd4 : r_mem_addr - 16'd4;
        end
    end

    // A fetch is launched the cycle after the memory address changes or the memory view is entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_q  <= 1'b0;
            r_start <= 1'b0;
            r_state <= S_IDLE;
            r_mem_q <= '0;
            r_reg_q <= '0;
        end else begin
            r_sw_q  <= switch_i;
            r_start <= w_idle & switch_i & (w_step | ~r_sw_q);
            r_state <= (w_idle && r_start) ? S_REQ : (!w_idle && dbg.mem_ack_i) ? S_IDLE : r_state;
            r_mem_q <= (!w_idle && dbg.mem_ack_i) ? dbg.mem_data_i : r_mem_q;
            r_reg_q <= dbg.reg_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || r_scan_cnt == SW'(SCAN_DIV - 1)) r_scan_cnt <= '0;
        else r_scan_cnt <= r_scan_cnt + 1'b1;
        if (rst_i) r_digit <= '0;
        else if (r_scan_cnt == SW'(SCAN_DIV - 1)) r_digit <= r_digit + 3'd1;
    end

    assign w_word         = switch_i ? r_mem_q : r_reg_q;
    assign w_nib          = w_word[{r_digit, 2'b00} +: 4];
    assign anode_o        = ~(8'b1 << r_digit);
    assign seg_o          = HEX7[w_nib];
    assign dbg.reg_addr_o = r_reg_addr;
    assign dbg.mem_addr_o = r_mem_addr;
    assign dbg.mem_req_o  = !w_idle;
    assign busy_o         = !w_idle;
    assign led_o          = switch_i ? r_mem_addr : {11'b0, r_reg_addr};
endmodule

// File: tb/tb_debug_view_sequencer.sv
// tb_debug_view_sequencer: directed checks of stepping, fetch handshake, display scan and reset.
module tb_debug_view_sequencer;
    logic        clk = 1'b0, rst = 1'b1, sw = 1'b0, bn = 1'b0, bp = 1'b0, au = 1'b0, ack = 1'b0;
    logic [31:0] rdata = '0, mdata = '0;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        busy;
    int          checks = 0, errors = 0;

    typedef struct { logic [7:0] an; logic [6:0] seg; } scan_t;
    scan_t tbl [16];

    debug_view_sequencer_if dbg();
    assign dbg.reg_data_i = rdata;
    assign dbg.mem_ack_i  = ack;
    assign dbg.mem_data_i = mdata;

    debug_view_sequencer #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .AUTO_STEP_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst), .switch_i(sw), .btn_next_i(bn), .btn_prev_i(bp), .auto_i(au),
        .dbg(dbg), .led_o(led), .anode_o(an), .seg_o(seg), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [7:0] v);
        for (int i = 0; i < 40 && an !== v; i++) @(negedge clk);
        chk("wait_anode", 32'(an), 32'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] dseg [8];
        logic [7:0] dan  [8];
        // 0xDEADBEEF, digit 0 first: F E E b d A E d
        dseg = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011, 7'b0100001, 7'b0001000, 7'b0000110, 7'b0100001};
        dan  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        for (int d = 0; d < 8; d++) begin
            tbl[2*d]   = '{dan[d], dseg[d]};
            tbl[2*d+1] = '{dan[d], dseg[d]};
        end

        cyc(3);
        chk("rst_reg_addr", 32'(dbg.reg_addr_o), 32'd0);
        chk("rst_mem_addr", 32'(dbg.mem_addr_o), 32'd0);
        chk("rst_mem_req", 32'(dbg.mem_req_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_anode", 32'(an), 32'hFE);
        chk("rst_seg", 32'(seg), 32'b1000000);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_reg", 32'(dbg.reg_addr_o), 32'd0);
        chk("post_rst_led", 32'(led), 32'd0);

        bn = 1'b1; cyc(2); bn = 1'b0; cyc(8);
        chk("glitch_no_step", 32'(dbg.reg_addr_o), 32'd0);
        bp = 1'b1; cyc(6);
        chk("prev_latency", 32'(dbg.reg_addr_o), 32'd0);
        cyc(1);
        chk("prev_wrap", 32'(dbg.reg_addr_o), 32'd31);
        chk("prev_led", 32'(led), 32'h001F);
        cyc(3); bp = 1'b0; cyc(8);
        chk("prev_single_step", 32'(dbg.reg_addr_o), 32'd31);
        bn = 1'b1; cyc(10); bn = 1'b0; cyc(8);
        chk("next_wrap", 32'(dbg.reg_addr_o), 32'd0);

        wait_an(8'h7F);
        wait_an(8'hFE);
        chk("regview_old_seg", 32'(seg), 32'b1000000);
        rdata = 32'h0000_0003;
        cyc(1);
        chk("regview_new_seg", 32'(seg), 32'b0110000);
        chk("regview_dwell", 32'(an), 32'hFE);
        cyc(1);
        chk("regview_next_digit", 32'(an), 32'hFD);
        chk("regview_digit1_seg", 32'(seg), 32'b1000000);

        sw = 1'b1; cyc(1);
        chk("fetch_not_yet", 32'(dbg.mem_req_o), 32'd0);
        cyc(1);
        chk("fetch_req", 32'(dbg.mem_req_o), 32'd1);
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_addr", 32'(dbg.mem_addr_o), 32'h0000);
        chk("fetch_led", 32'(led), 32'h0000);
        cyc(2);
        chk("fetch_wait", 32'(dbg.mem_req_o), 32'd1);
        ack = 1'b1; mdata = 32'hDEADBEEF; cyc(1); ack = 1'b0;
        chk("fetch_done_req", 32'(dbg.mem_req_o), 32'd0);
        chk("fetch_done_busy", 32'(busy), 32'd0);
        wait_an(8'h7F);
        wait_an(8'hFE);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("scan_an%0d", i), 32'(an), 32'(tbl[i].an));
            chk($sformatf("scan_seg%0d", i), 32'(seg), 32'(tbl[i].seg));
            cyc(1);
        end

        bp = 1'b1; cyc(6);
        chk("mem_prev_latency", 32'(dbg.mem_addr_o), 32'h0000);
        cyc(1);
        chk("mem_prev_wrap", 32'(dbg.mem_addr_o), 32'hFFFC);
        chk("mem_prev_led", 32'(led), 32'hFFFC);
        chk("mem_req_lag", 32'(dbg.mem_req_o), 32'd0);
        cyc(1);
        chk("mem_req_rise", 32'(dbg.mem_req_o), 32'd1);
        cyc(2); bp = 1'b0;
        bn = 1'b1; cyc(10); bn = 1'b0; cyc(8);
        chk("dropped_step_addr", 32'(dbg.mem_addr_o), 32'hFFFC);
        chk("dropped_step_req", 32'(dbg.mem_req_o), 32'd1);
        chk("reg_untouched", 32'(dbg.reg_addr_o), 32'd0);
        ack = 1'b1; mdata = 32'h1234_5678; cyc(1); ack = 1'b0;
        chk("fetch2_done", 32'(dbg.mem_req_o), 32'd0);

        sw = 1'b0; au = 1'b1; cyc(15);
        chk("auto_before", 32'(dbg.reg_addr_o), 32'd0);
        cyc(1);
        chk("auto_step1", 32'(dbg.reg_addr_o), 32'd1);
        cyc(16);
        chk("auto_step2", 32'(dbg.reg_addr_o), 32'd2);
        bn = 1'b1; bp = 1'b1; cyc(8);
        chk("cancel_no_step", 32'(dbg.reg_addr_o), 32'd2);
        cyc(2); bn = 1'b0; bp = 1'b0; cyc(5);
        chk("cancel_timer_kept_a", 32'(dbg.reg_addr_o), 32'd2);
        cyc(1);
        chk("cancel_timer_kept_b", 32'(dbg.reg_addr_o), 32'd3);
        au = 1'b0;

        sw = 1'b1; cyc(2);
        chk("midfetch_req", 32'(dbg.mem_req_o), 32'd1);
        chk("midfetch_addr", 32'(dbg.mem_addr_o), 32'hFFFC);
        rst = 1'b1; cyc(1);
        chk("midfetch_rst_req", 32'(dbg.mem_req_o), 32'd0);
        chk("midfetch_rst_busy", 32'(busy), 32'd0);
        chk("midfetch_rst_addr", 32'(dbg.mem_addr_o), 32'h0000);
        chk("midfetch_rst_memq", 32'(seg), 32'b1000000);
        rst = 1'b0; sw = 1'b0; ack = 1'b1; mdata = 32'hFFFF_FFFF; cyc(1);
        ack = 1'b0; sw = 1'b1;
        chk("late_ack_an", 32'(an), 32'hFE);
        chk("late_ack_ignored", 32'(seg), 32'b1000000);
        chk("late_ack_idle", 32'(dbg.mem_req_o), 32'd0);
        cyc(2);
        chk("refetch_req", 32'(dbg.mem_req_o), 32'd1);
        ack = 1'b1; mdata = 32'h0000_00A5; cyc(1); ack = 1'b0;
        chk("refetch_done", 32'(dbg.mem_req_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_view_sequencer.md
# debug_view_sequencer

Sequencing controller for the board debug view: walks register-file and data-memory addresses from debounced push-buttons or an auto-step timer, fetches the selected word, and drives an 8-digit multiplexed seven-segment display plus the 16 status LEDs. It sits between the board I/O and the processor's debug read ports: the register-file read port is combinational, and the data-memory read port uses a request/acknowledge handshake.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change
- SCAN_DIV, 100_000, cycles per digit in the display multiplex
- AUTO_STEP_CYCLES, 100_000_000, cycles between automatic "next" steps
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous, active-high
- switch_i  in  1  view select: 0 register view, 1 memory view
- btn_next_i  in  1  raw button input, step forward
- btn_prev_i  in  1  raw button input, step backward
- auto_i  in  1  auto-step enable
- reg_addr_o  out  5  register-file debug read address
- reg_data_i  in  32  register-file read data, combinational from reg_addr_o
- mem_addr_o  out  16  data-memory debug byte address
- mem_req_o  out  1  memory read request
- mem_ack_i  in  1  memory read acknowledge; mem_data_i is valid in the same cycle
- mem_data_i  in  32  memory read data
- led_o  out  16  in memory view: mem_addr_o; in register view: {11'b0, reg_addr_o}
- anode_o  out  8  digit enables, active-low
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- busy_o  out  1  high while a memory fetch is outstanding

## Operation
- **Buttons**
  - Each button passes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level.
  - A rising edge of the debounced level produces a one-cycle step pulse.
- **Step rules**
  - next and prev pulses in the same cycle cancel; no step is taken.
  - The auto timer counts while auto_i=1 and produces a "next" pulse at terminal count.
  - The auto timer clears on any step, on auto_i=0 and on reset.
- **Addresses**
  - Each view keeps its own address; a step applies only to the active view.
  - Register view: reg_addr_o ±1 modulo 32 (31→0, 0→31).
  - Memory view: mem_addr_o ±4 modulo 2^16 (0xFFFC→0x0000, 0x0000→0xFFFC).
- **Fetch FSM (IDLE, REQ)**
  - IDLE→REQ in the cycle after either a memory-view step or a detected 0→1 change of registered switch_q.
  - switch_q resets to 0, so switch_i=1 after reset triggers a fetch.
  - In REQ: mem_req_o=1 and busy_o=1, with mem_addr_o held stable.
  - On mem_ack_i in REQ: capture mem_data_i into mem_q and return to IDLE.
  - mem_ack_i in IDLE is ignored.
  - Step pulses in either view while in REQ are dropped; addresses do not change.
  - Switching to register view during REQ does not abort the request; the completed data still loads mem_q.
- **Display data**
  - reg_q <= reg_data_i every cycle.
  - Displayed word = switch_i ? mem_q : reg_q.
- **Multiplex**
  - A 3-bit digit index advances every SCAN_DIV cycles and wraps 7→0.
  - anode_o = ~(8'b1 << digit).
  - seg_o = hex decode of word[4*digit+3 : 4*digit]; digit 0 is the least significant nibble.
  - Hex encoding {g..a}, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Reset**
  - All counters, addresses, reg_q, mem_q, switch_q and the FSM state (IDLE) reset to 0.
  - Reset mid-fetch drops mem_req_o in the next cycle.

## Timing
- Reset values: reg_addr_o=0, mem_addr_o=0, mem_req_o=0, busy_o=0, led_o=0, anode_o=8'hFE, seg_o=7'b1000000.
- Button latency: raw edge to address change = 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
- Fetch start: mem_req_o rises 1 cycle after the address register updates.
- Fetch end: in the ack cycle mem_q loads; mem_req_o and busy_o are low in the following cycle.
- Register view: display reflects reg_data_i 1 cycle later.
- Digit dwell: exactly SCAN_DIV cycles per digit; full refresh = 8·SCAN_DIV cycles.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SCAN_DIV=2, AUTO_STEP_CYCLES=16.

- **Reset:** hold rst_i 3 cycles with switch_i=0 → all reset values above hold; release → reg_addr_o=0, led_o=0x0000.
- **Debounce, register wrap:** 2-cycle glitch on btn_next_i → no step. Then btn_prev_i held 10 cycles → reg_addr_o=31, led_o=0x001F. Then btn_next_i held → reg_addr_o=0.
- **Memory fetch handshake:** switch_i 0→1 → mem_req_o=1 with mem_addr_o=0x0000. Ack after 3 cycles with mem_data_i=0xDEADBEEF → mem_q=0xDEADBEEF, mem_req_o=0 next cycle. Across 16 cycles, digits 7..0 show D,E,A,D,B,E,E,F on anodes 0x7F..0xFE.
- **Memory wrap, dropped step:** from mem_addr_o=0x0000 press prev → 0xFFFC and a fetch starts. Press next while waiting for ack → mem_addr_o stays 0xFFFC.
- **Auto step, cancel:** auto_i=1 in register view → reg_addr_o increments every 16 cycles. Simultaneous next and prev pulses → no change, and the auto timer is not cleared.
- **Reset mid-fetch:** assert rst_i while in REQ → mem_req_o=0 the next cycle, FSM in IDLE, mem_q=0. A late mem_ack_i is ignored.
